// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: merges load-use, branch, imem-wait and multi-cycle EX
// handshakes into pipeline enables/flushes, with watchdog and stall counter.
module pipeline_control_unit #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             branch_taken_ex,
  input  logic             mc_op_ex,
  input  logic             mc_done,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;
  localparam int WD_W = $clog2(MC_TIMEOUT);
  logic [0:0] state, nextState;
  logic [WD_W-1:0] wdogCnt;
  logic wdogExpired, mcRelease;
  assign wdogExpired = state == MC_WAIT && !mc_done && wdogCnt == WD_W'(MC_TIMEOUT - 1);
  assign mcRelease = state == MC_WAIT && (mc_done || wdogExpired);
  always_comb begin
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    id_ex_hold = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_start = 1'b0;
    nextState = state;
    if (reset) begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      nextState = RUN;
    end else if (state == RUN) begin
      if (mc_op_ex) begin
        mc_start = 1'b1;
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_hold = 1'b1;
        ex_mem_bubble = 1'b1;
        nextState = MC_WAIT;
      end else if (branch_taken_ex) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_stall) begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_write = 1'b0;
        if_id_flush = 1'b1;
      end
    end else if (mcRelease) begin
      // EX/MEM captures the multi-cycle result; fetch may still be waiting
      nextState = RUN;
      pc_write = imem_ready;
      if_id_flush = !imem_ready;
    end else begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold = 1'b1;
      ex_mem_bubble = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wdogCnt <= '0;
      mc_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= nextState;
      wdogCnt <= state == RUN ? '0 : wdogCnt + 1'b1;
      if (wdogExpired) mc_timeout <= 1'b1;
      if (!pc_write && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule
